// File: rtl/rr_mux_pkg.sv
// ----------------------------------------------------------------------------
// rr_mux_pkg
// Shared types and helpers for the round-robin stream multiplexer family.
//   arb_state_e : grant lock state (free to re-arbitrate / locked on rr_ptr)
//   sel_width   : width of a channel index, never less than one bit
//   next_idx    : wrap-around increment of a channel index
// ----------------------------------------------------------------------------
package rr_mux_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int next_idx(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// ----------------------------------------------------------------------------
// rr_stream_mux_if
// Bundle of the N input streams and the single output stream of the mux.
//   in_data   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel valid
//   in_last   CHANNELS        per-channel end-of-packet
//   in_ready  CHANNELS        per-channel ready (from the mux)
//   out_data  WIDTH           held beat
//   out_valid 1               held beat valid
//   out_last  1               held beat last flag
//   out_sel   SELW            channel that supplied the held beat
//   out_ready 1               downstream ready
// Modports: slave = the mux itself, master = producers/consumer around it.
// ----------------------------------------------------------------------------
interface rr_stream_mux_if
    import rr_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    localparam int SELW = sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_last;
    logic [SELW-1:0]           out_sel;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.
//   req          CHANNELS  request vector
//   rr_ptr       SELW      highest-priority channel this cycle
//   lock         1         when set only rr_ptr may be granted
//   grant_onehot CHANNELS  one-hot grant (all zero when nothing granted)
//   grant_idx    SELW      index of the granted channel
// ----------------------------------------------------------------------------
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     rr_ptr,
    input  logic                lock,
    output logic [CHANNELS-1:0] grant_onehot,
    output logic [SELW-1:0]     grant_idx
);

    logic w_found;

    // Search rr_ptr, rr_ptr+1, ... with wrap; first requester wins.
    always_comb begin
        int cand;
        cand      = 0;
        w_found   = 1'b0;
        grant_idx = '0;
        if (lock) begin
            // Locked: the packet owner keeps priority even while idle.
            w_found   = req[rr_ptr];
            grant_idx = rr_ptr;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= CHANNELS) begin
                    cand = cand - CHANNELS;
                end
                if (!w_found && req[cand]) begin
                    w_found   = 1'b1;
                    grant_idx = SELW'(cand);
                end
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_onehot
        assign grant_onehot[gi] = w_found && (grant_idx == SELW'(gi));
    end

endmodule

// File: rtl/rr_stream_mux.sv
// ----------------------------------------------------------------------------
// rr_stream_mux
// N:1 stream multiplexer with round-robin selection and a single registered
// output stage with backpressure. In packet mode the grant stays on one
// channel until a beat flagged last is accepted from it.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_stream_mux_if.slave (input streams, output stream)
// ----------------------------------------------------------------------------
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int PACKET_MODE = 0,
    parameter int SELW        = sel_width(CHANNELS)
) (
    input  logic               clk,
    input  logic               rst,
    rr_stream_mux_if.slave     bus
);

    logic [SELW-1:0]     r_ptr;
    arb_state_e          r_lock;
    logic [WIDTH-1:0]    r_data;
    logic                r_last;
    logic                r_valid;
    logic [SELW-1:0]     r_sel;

    logic [CHANNELS-1:0] w_grant_onehot;
    logic [SELW-1:0]     w_grant_idx;
    logic                w_grant_any;
    logic                w_lock;
    logic                w_load;
    logic                w_accept;
    logic [WIDTH-1:0]    w_data;
    logic                w_last;
    logic [SELW-1:0]     w_ptr_next;
    logic [WIDTH-1:0]    w_masked [CHANNELS];

    assign w_lock = (r_lock == ARB_LOCKED);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .req          (bus.in_valid),
        .rr_ptr       (r_ptr),
        .lock         (w_lock),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx)
    );

    // The output register can take a new beat when empty or draining.
    assign w_grant_any = |w_grant_onehot;
    assign w_load      = !r_valid || bus.out_ready;
    assign w_accept    = w_load && w_grant_any && !rst;
    assign bus.in_ready = w_grant_onehot & {CHANNELS{w_load && !rst}};

    // AND-OR data mux: non-granted lanes are forced to zero so unknown
    // data on idle producers cannot leak into the output register.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
        assign w_masked[gi] = bus.in_data[gi*WIDTH +: WIDTH] & {WIDTH{w_grant_onehot[gi]}};
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_data = w_data | w_masked[k];
        end
    end

    assign w_last     = |(bus.in_last & w_grant_onehot);
    assign w_ptr_next = SELW'(next_idx(int'(w_grant_idx), CHANNELS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_lock  <= ARB_FREE;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_sel   <= '0;
        end else if (w_load) begin
            if (w_accept) begin
                r_data  <= w_data;
                r_last  <= w_last;
                r_sel   <= w_grant_idx;
                r_valid <= 1'b1;
                if (PACKET_MODE != 0 && !w_last) begin
                    // Mid-packet: stay on this channel.
                    r_ptr  <= w_grant_idx;
                    r_lock <= ARB_LOCKED;
                end else begin
                    r_ptr  <= w_ptr_next;
                    r_lock <= ARB_FREE;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_last  = r_last;
    assign bus.out_valid = r_valid;
    assign bus.out_sel   = r_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// ----------------------------------------------------------------------------
// tb_rr_stream_mux
// Directed bench: dut0 runs beat-by-beat round-robin, dut1 runs packet mode.
// ----------------------------------------------------------------------------
module tb_rr_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;
    int   checks = 0;
    int   errors = 0;

    rr_stream_mux_if #(.WIDTH(8), .CHANNELS(4)) bus0 ();
    rr_stream_mux_if #(.WIDTH(8), .CHANNELS(4)) bus1 ();

    rr_stream_mux #(.WIDTH(8), .CHANNELS(4), .PACKET_MODE(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    rr_stream_mux #(.WIDTH(8), .CHANNELS(4), .PACKET_MODE(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out0(input string tag, input logic v, input logic [7:0] d,
                              input logic l, input logic [1:0] s);
        check({tag, ".valid"}, 32'(bus0.out_valid), 32'(v));
        check({tag, ".data"},  32'(bus0.out_data),  32'(d));
        check({tag, ".last"},  32'(bus0.out_last),  32'(l));
        check({tag, ".sel"},   32'(bus0.out_sel),   32'(s));
    endtask

    task automatic check_out1(input string tag, input logic v, input logic [7:0] d,
                              input logic l, input logic [1:0] s);
        check({tag, ".valid"}, 32'(bus1.out_valid), 32'(v));
        check({tag, ".data"},  32'(bus1.out_data),  32'(d));
        check({tag, ".last"},  32'(bus1.out_last),  32'(l));
        check({tag, ".sel"},   32'(bus1.out_sel),   32'(s));
    endtask

    initial begin
        // ---------------- reset, all channels valid ----------------
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus0.in_valid  = 4'b1111;
        bus0.in_last   = 4'b1000;
        bus0.out_ready = 1'b1;
        bus1.in_data   = {8'h40, 8'h30, 8'h21, 8'h10};
        bus1.in_valid  = 4'b0000;
        bus1.in_last   = 4'b0000;
        bus1.out_ready = 1'b1;
        tick();
        tick();
        check("rst.in_ready", 32'(bus0.in_ready), 32'h0);
        check_out0("rst.out0", 1'b0, 8'h00, 1'b0, 2'd0);
        check("rst.valid1", 32'(bus1.out_valid), 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(bus0.in_ready), 32'b0001);

        // ---------------- round-robin fairness ----------------
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out0($sformatf("rr%0d", k), 1'b1, 8'hA0 + 8'(k % 4),
                       (k % 4) == 3, 2'(k % 4));
            $display("rr beat %0d: sel=%0d data=%0h", k, bus0.out_sel, bus0.out_data);
        end

        // ---------------- sparse requests (ptr=1) ----------------
        bus0.in_valid = 4'b0100;
        bus0.in_data[15:8] = 8'hxx;   // ungranted channel carries X
        #1;
        check("sp0.in_ready", 32'(bus0.in_ready), 32'b0100);
        tick();
        check_out0("sp0", 1'b1, 8'hA2, 1'b0, 2'd2);
        $display("sparse beat: sel=%0d data=%0h", bus0.out_sel, bus0.out_data);
        bus0.in_data[15:8] = 8'hA1;
        bus0.in_valid = 4'b1001;
        #1;
        check("sp1.in_ready", 32'(bus0.in_ready), 32'b1000);
        tick();
        check_out0("sp1", 1'b1, 8'hA3, 1'b1, 2'd3);
        check("sp2.in_ready", 32'(bus0.in_ready), 32'b0001);
        tick();
        check_out0("sp2", 1'b1, 8'hA0, 1'b0, 2'd0);
        $display("sparse beat: sel=%0d data=%0h", bus0.out_sel, bus0.out_data);

        // ---------------- idle: valid drops, fields hold ----------------
        bus0.in_valid = 4'b0000;
        #1;
        check("idle.in_ready", 32'(bus0.in_ready), 32'h0);
        tick();
        check_out0("idle", 1'b0, 8'hA0, 1'b0, 2'd0);

        // ---------------- backpressure (ptr=1) ----------------
        bus0.in_valid = 4'b1111;
        #1;
        check("bp.in_ready0", 32'(bus0.in_ready), 32'b0010);
        tick();
        check_out0("bp.first", 1'b1, 8'hA1, 1'b0, 2'd1);
        bus0.out_ready = 1'b0;
        #1;
        check("bp.stall_ready", 32'(bus0.in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out0($sformatf("bp.hold%0d", k), 1'b1, 8'hA1, 1'b0, 2'd1);
            check($sformatf("bp.hold%0d.in_ready", k), 32'(bus0.in_ready), 32'h0);
            $display("stall cycle %0d: sel=%0d data=%0h", k, bus0.out_sel, bus0.out_data);
        end
        bus0.out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(bus0.in_ready), 32'b0100);
        tick();
        check_out0("bp.next", 1'b1, 8'hA2, 1'b0, 2'd2);
        tick();
        check_out0("bp.next2", 1'b1, 8'hA3, 1'b1, 2'd3);
        bus0.in_valid = 4'b0000;
        tick();
        check("bp.drain", 32'(bus0.out_valid), 32'h0);

        // ---------------- packet mode: single-beat packet from ch0 ----------------
        bus1.in_valid = 4'b0001;
        bus1.in_last  = 4'b0101;
        #1;
        check("pk.single_ready", 32'(bus1.in_ready), 32'b0001);
        tick();
        check_out1("pk.single", 1'b1, 8'h10, 1'b1, 2'd0);

        // ch1 3-beat packet with ch0 and ch2 competing
        bus1.in_valid = 4'b0111;
        #1;
        check("pk.b1_ready", 32'(bus1.in_ready), 32'b0010);
        tick();
        check_out1("pk.b1", 1'b1, 8'h21, 1'b0, 2'd1);
        $display("packet beat 1: sel=%0d data=%0h", bus1.out_sel, bus1.out_data);
        bus1.in_valid = 4'b0101;      // owner goes idle for two cycles
        #1;
        check("pk.gap_ready0", 32'(bus1.in_ready), 32'h0);
        tick();
        check("pk.gap0.valid", 32'(bus1.out_valid), 32'h0);
        check("pk.gap1_ready", 32'(bus1.in_ready), 32'h0);
        tick();
        check("pk.gap1.valid", 32'(bus1.out_valid), 32'h0);
        bus1.in_valid = 4'b0111;
        bus1.in_data[15:8] = 8'h22;
        #1;
        check("pk.b2_ready", 32'(bus1.in_ready), 32'b0010);
        tick();
        check_out1("pk.b2", 1'b1, 8'h22, 1'b0, 2'd1);
        $display("packet beat 2: sel=%0d data=%0h", bus1.out_sel, bus1.out_data);
        bus1.in_data[15:8] = 8'h23;
        bus1.in_last = 4'b0111;
        #1;
        check("pk.b3_ready", 32'(bus1.in_ready), 32'b0010);
        tick();
        check_out1("pk.b3", 1'b1, 8'h23, 1'b1, 2'd1);
        $display("packet beat 3: sel=%0d data=%0h", bus1.out_sel, bus1.out_data);
        check("pk.after_ready", 32'(bus1.in_ready), 32'b0100);
        tick();
        check_out1("pk.ch2", 1'b1, 8'h30, 1'b1, 2'd2);
        check("pk.ch0_ready", 32'(bus1.in_ready), 32'b0001);
        tick();
        check_out1("pk.ch0", 1'b1, 8'h10, 1'b1, 2'd0);

        // ---------------- mid-packet reset (ptr=1) ----------------
        bus1.in_valid = 4'b0011;
        bus1.in_last  = 4'b0001;
        bus1.in_data[15:8] = 8'h21;
        #1;
        check("mr.b1_ready", 32'(bus1.in_ready), 32'b0010);
        tick();
        check_out1("mr.b1", 1'b1, 8'h21, 1'b0, 2'd1);
        bus1.in_data[15:8] = 8'h22;
        #1;
        check("mr.b2_ready", 32'(bus1.in_ready), 32'b0010);
        tick();
        check_out1("mr.b2", 1'b1, 8'h22, 1'b0, 2'd1);
        rst1 = 1'b1;
        #1;
        check("mr.rst_ready", 32'(bus1.in_ready), 32'h0);
        tick();
        check_out1("mr.rst", 1'b0, 8'h00, 1'b0, 2'd0);
        rst1 = 1'b0;
        bus1.in_valid = 4'b0101;
        #1;
        check("mr.post_ready", 32'(bus1.in_ready), 32'b0001);
        tick();
        check_out1("mr.post", 1'b1, 8'h10, 1'b1, 2'd0);
        $display("after reset beat: sel=%0d data=%0h", bus1.out_sel, bus1.out_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N:1 stream multiplexer, the successor to the 2:1 mux.
- Selection is made by a round-robin arbiter, not by an external select line.
- Each input channel has a valid/ready handshake; the output stage is a single registered stage with backpressure.
- Optional packet mode keeps the grant on one channel until that channel's last beat.
- Sits between multiple producers and one shared consumer.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- CHANNELS, 4, number of input channels (>=2).
- PACKET_MODE, 0, 0 = re-arbitrate after every beat; 1 = hold grant until a beat with in_last is accepted.
- SELW, $clog2(CHANNELS), width of out_sel (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_last  input  CHANNELS  per-channel end-of-packet marker.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last flag of the held beat.
- out_sel  output  SELW  index of the channel that supplied the held beat.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset: one clock, synchronous, active-high. Every registered signal is set to 0: out_valid, out_data, out_last, out_sel, rr_ptr and lock.
  - Reset mid-packet drops the held beat and clears the lock.
  - in_ready is 0 while rst is high.
- Load condition:
  - load = !out_valid || out_ready.
  - A beat transfers on an input when in_valid[i] && in_ready[i].
  - A beat transfers on the output when out_valid && out_ready.
- Arbitration (combinational):
  - grant is the first channel i with in_valid[i], searching from rr_ptr upward with wrap-around from CHANNELS-1 to 0.
  - When lock=1, only the channel at rr_ptr is eligible. Other channels wait even if that channel is idle.
  - in_ready[i] = load && grant_onehot[i] && !rst. At most one bit is high.
- On an accepted beat from channel g:
  - out_data <= in_data[g]; out_last <= in_last[g]; out_sel <= g; out_valid <= 1.
- If load=1 and no input beat is accepted: out_valid <= 0, and out_data, out_last and out_sel hold their values.
- Pointer update, PACKET_MODE=0: after each accepted beat, rr_ptr <= (g+1) mod CHANNELS. lock stays 0.
- Pointer update, PACKET_MODE=1:
  - Accepted beat with in_last[g]=0: rr_ptr <= g, lock <= 1.
  - Accepted beat with in_last[g]=1: rr_ptr <= (g+1) mod CHANNELS, lock <= 0.
  - A single-beat packet (last on first beat) never sets lock.
- Latency and throughput:
  - Input to output latency is 1 cycle.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - Output register refill happens in the same cycle as the output transfer (no bubble).
- Backpressure:
  - While out_valid=1 and out_ready=0: out_data, out_last, out_sel and out_valid are stable, and all in_ready are 0.
- Fairness: with every channel continuously valid and PACKET_MODE=0, the grant order is 0,1,...,CHANNELS-1,0,...
- in_data is not sampled for channels that are not granted. X on non-granted channels must not propagate to the outputs.

Decomposition:
- Shared package rr_mux_pkg holds:
  - function sel_width(n) = max(1, $clog2(n)).
  - function next_idx(i, n) for the wrap-around increment.
- One natural sub-module, rr_arbiter. Inputs: req[CHANNELS], rr_ptr, lock. Outputs: grant_onehot, grant_idx.
  - Purely combinational.
  - Reusable by later multi-master blocks.
- The top level holds the output register, rr_ptr and lock.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_sel=0. After release, the first grant is channel 0.
- Round-robin (CHANNELS=4, PACKET_MODE=0): in_valid=1111, data per channel i = 8'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0, one per cycle after 1-cycle latency.
- Sparse requests: in_valid=0100 for 1 cycle, then 1001 -> beats from ch2, then ch3, then ch0, with out_sel=2,3,0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> outputs frozen and in_ready=0000. Release -> the next beat follows with no loss or duplication.
- Packet lock (PACKET_MODE=1): ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are valid throughout -> three consecutive ch1 beats, then ch2, then ch0. Lock holds even if ch1 drops valid for 2 cycles mid-packet.
- Mid-packet reset: assert rst after beat 2 of a ch1 packet -> out_valid=0 next cycle, lock cleared, next grant from channel 0.
